// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//
// Fixed-time controller for a T-junction with four signal heads:
//   M1 - main road, direction 1
//   M2 - main road, direction 2
//   MT - main road turn lane
//   S  - side road
//
// A free-running six-phase state machine steps P1..P6 forever.
// Each phase is held for a parameterised number of clock ticks.
// With the nominal 1 Hz clock, one tick is one second.
// Lamp outputs are a purely combinational decode of the current phase.
//
// Lamp encoding, one-hot {red,yellow,green}:
//   RED = 3'b100, YEL = 3'b010, GRN = 3'b001
//
// Parameters:
//   T_MAIN - ticks in P1 (M1+M2 green)
//   T_YEL  - ticks in each yellow phase (P2, P4, P6)
//   T_TURN - ticks in P3 (M1+MT green)
//   T_SIDE - ticks in P5 (S green)
//   CNT_W  - timer width; must hold the largest duration minus 1
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst      in   asynchronous, active-low reset
//   light_M1 out  main road dir-1 head
//   light_M2 out  main road dir-2 head
//   light_MT out  main turn-lane head
//   light_S  out  side road head
// -----------------------------------------------------------------------------
module traffic_light_ctrl #(
  parameter int T_MAIN = 7,
  parameter int T_YEL  = 2,
  parameter int T_TURN = 5,
  parameter int T_SIDE = 3,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Encodings 3'd6 and 3'd7 are unreachable.
  // The next-state and output decodes still handle them explicitly.
  typedef enum logic [2:0] {
    P1 = 3'd0,
    P2 = 3'd1,
    P3 = 3'd2,
    P4 = 3'd3,
    P5 = 3'd4,
    P6 = 3'd5
  } phase_t;

  localparam logic [CNT_W-1:0] LAST_MAIN = CNT_W'(T_MAIN - 1);
  localparam logic [CNT_W-1:0] LAST_YEL  = CNT_W'(T_YEL  - 1);
  localparam logic [CNT_W-1:0] LAST_TURN = CNT_W'(T_TURN - 1);
  localparam logic [CNT_W-1:0] LAST_SIDE = CNT_W'(T_SIDE - 1);

  phase_t           phase;
  phase_t           phase_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] last_tick;
  logic             legal;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= P1;
      cnt   <= '0;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Dwell decode: timer value on which the current phase ends
  // ---------------------------------------------------------------------------
  always_comb begin
    last_tick = '0;
    legal     = 1'b1;
    case (phase)
      P1:      last_tick = LAST_MAIN;
      P2:      last_tick = LAST_YEL;
      P3:      last_tick = LAST_TURN;
      P4:      last_tick = LAST_YEL;
      P5:      last_tick = LAST_SIDE;
      P6:      last_tick = LAST_YEL;
      default: legal     = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_nxt = P1;
    cnt_nxt   = '0;
    if (!legal) begin
      // Recover from a corrupted phase register on the next edge.
      phase_nxt = P1;
      cnt_nxt   = '0;
    end else if (cnt == last_tick) begin
      cnt_nxt = '0;
      case (phase)
        P1:      phase_nxt = P2;
        P2:      phase_nxt = P3;
        P3:      phase_nxt = P4;
        P4:      phase_nxt = P5;
        P5:      phase_nxt = P6;
        P6:      phase_nxt = P1;
        default: phase_nxt = P1;
      endcase
    end else begin
      phase_nxt = phase;
      cnt_nxt   = cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // Driven from phase only.
  // Illegal encodings show all-red.
  // ---------------------------------------------------------------------------
  always_comb begin
    light_M1 = RED;
    light_M2 = RED;
    light_MT = RED;
    light_S  = RED;
    case (phase)
      P1: begin
        light_M1 = GRN;
        light_M2 = GRN;
      end
      P2: begin
        light_M1 = GRN;
        light_M2 = YEL;
      end
      P3: begin
        light_M1 = GRN;
        light_MT = GRN;
      end
      P4: begin
        light_M1 = YEL;
        light_MT = YEL;
      end
      P5:      light_S = GRN;
      P6:      light_S = YEL;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//
// Self-checking bench for traffic_light_ctrl.
//
// Two instances share the clock and reset:
//   dut1 - default timing (21-tick cycle)
//   dut2 - T_MAIN=3, T_SIDE=1 (15-tick cycle)
//
// Expected lamp patterns come from a phase-duration table and the elapsed
// tick count since reset release.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk;
  logic       rst;
  logic [2:0] m1_a, m2_a, mt_a, s_a;
  logic [2:0] m1_b, m2_b, mt_b, s_b;

  int ncmp;
  int nerr;
  int k;

  traffic_light_ctrl dut1 (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (m1_a),
    .light_M2 (m2_a),
    .light_MT (mt_a),
    .light_S  (s_a)
  );

  traffic_light_ctrl #(
    .T_MAIN (3),
    .T_SIDE (1)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (m1_b),
    .light_M2 (m2_b),
    .light_MT (mt_b),
    .light_S  (s_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lamp pattern {M1,M2,MT,S} for phase index 0..5.
  function automatic logic [11:0] pat(input int idx);
    logic [11:0] r;
    case (idx)
      0:       r = {GRN, GRN, RED, RED};
      1:       r = {GRN, YEL, RED, RED};
      2:       r = {GRN, RED, GRN, RED};
      3:       r = {YEL, RED, YEL, RED};
      4:       r = {RED, RED, RED, GRN};
      5:       r = {RED, RED, RED, YEL};
      default: r = {RED, RED, RED, RED};
    endcase
    return r;
  endfunction

  // Expected pattern after k edges since release, for given main/side dwell.
  function automatic logic [11:0] model(input int kk, input int tm, input int ts);
    int          d[6];
    int          cyc;
    int          pos;
    bit          found;
    logic [11:0] r;
    d     = '{tm, 2, 5, 2, ts, 2};
    cyc   = 0;
    found = 1'b0;
    r     = '0;
    for (int i = 0; i < 6; i++) cyc += d[i];
    pos = kk % cyc;
    for (int i = 0; i < 6; i++) begin
      if (!found && pos < d[i]) begin
        r     = pat(i);
        found = 1'b1;
      end else if (!found) begin
        pos -= d[i];
      end
    end
    return r;
  endfunction

  function automatic bit onehot(input logic [2:0] v);
    return (v == RED) || (v == YEL) || (v == GRN);
  endfunction

  function automatic bit safe(input logic [11:0] v);
    logic [2:0] m1, m2, mt, s;
    {m1, m2, mt, s} = v;
    return !((s != RED) && ((m1 != RED) || (m2 != RED) || (mt != RED)))
        && !((m2 != RED) && (mt != RED));
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s k=%0d: got %b required %b", name, k, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s k=%0d: got %0d required %0d", name, k, act, exp);
    end
  endtask

  // Checks both instances against the model.
  // Also checks one-hot encoding and the safety invariants.
  task automatic check_all(input string name);
    logic [11:0] a, b;
    a = {m1_a, m2_a, mt_a, s_a};
    b = {m1_b, m2_b, mt_b, s_b};
    check({name, "_dut1"}, a, model(k, 7, 3));
    check({name, "_dut2"}, b, model(k, 3, 1));
    check_int({name, "_onehot1"},
              int'(onehot(m1_a) & onehot(m2_a) & onehot(mt_a) & onehot(s_a)), 1);
    check_int({name, "_onehot2"},
              int'(onehot(m1_b) & onehot(m2_b) & onehot(mt_b) & onehot(s_b)), 1);
    check_int({name, "_safe1"}, int'(safe(a)), 1);
    check_int({name, "_safe2"}, int'(safe(b)), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Async reset pulse placed between edges.
  // P1 must appear without any clock edge.
  task automatic async_pulse(input string name);
    #2;
    rst = 1'b0;
    #1;
    check({name, "_imm1"}, {m1_a, m2_a, mt_a, s_a}, pat(0));
    check({name, "_imm2"}, {m1_b, m2_b, mt_b, s_b}, pat(0));
    #1;
    rst = 1'b1;
    k   = 0;
  endtask

  typedef struct {
    int          kk;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [11:0] prev1, prev2;
    int          last1, last2;

    ncmp = 0;
    nerr = 0;
    k    = 0;

    // Directed table for the default-timing instance.
    tbl[0]  = '{0,  {GRN, GRN, RED, RED}};
    tbl[1]  = '{6,  {GRN, GRN, RED, RED}};
    tbl[2]  = '{7,  {GRN, YEL, RED, RED}};
    tbl[3]  = '{8,  {GRN, YEL, RED, RED}};
    tbl[4]  = '{9,  {GRN, RED, GRN, RED}};
    tbl[5]  = '{13, {GRN, RED, GRN, RED}};
    tbl[6]  = '{14, {YEL, RED, YEL, RED}};
    tbl[7]  = '{15, {YEL, RED, YEL, RED}};
    tbl[8]  = '{16, {RED, RED, RED, GRN}};
    tbl[9]  = '{18, {RED, RED, RED, GRN}};
    tbl[10] = '{19, {RED, RED, RED, YEL}};
    tbl[11] = '{20, {RED, RED, RED, YEL}};
    tbl[12] = '{21, {GRN, GRN, RED, RED}};
    tbl[13] = '{28, {GRN, YEL, RED, RED}};

    // Reset state before any clock edge.
    rst = 1'b0;
    #1;
    check("reset_dut1", {m1_a, m2_a, mt_a, s_a}, {GRN, GRN, RED, RED});
    check("reset_dut2", {m1_b, m2_b, mt_b, s_b}, {GRN, GRN, RED, RED});

    // Held in reset across an edge, then released between edges.
    @(posedge clk);
    #1;
    check("reset_held", {m1_a, m2_a, mt_a, s_a}, {GRN, GRN, RED, RED});
    #2;
    rst = 1'b1;
    k   = 0;

    // Table-driven walk through one full cycle.
    for (int i = 0; i < 14; i++) begin
      while (k < tbl[i].kk) tick();
      check($sformatf("tbl%0d", i), {m1_a, m2_a, mt_a, s_a}, tbl[i].exp);
      check($sformatf("tbl%0d_dut2", i), {m1_b, m2_b, mt_b, s_b}, model(k, 3, 1));
    end

    // Reset mid-P4, followed by a full P1 dwell.
    while ((k % 21) != 15) tick();
    async_pulse("rst_p4");
    for (int j = 1; j <= 7; j++) begin
      tick();
      check($sformatf("p4_dwell%0d", j), {m1_a, m2_a, mt_a, s_a},
            (j < 7) ? pat(0) : pat(1));
    end

    // Reset mid-P5, followed by a full P1 dwell.
    while ((k % 21) != 17) tick();
    check("pre_p5", {m1_a, m2_a, mt_a, s_a}, pat(4));
    async_pulse("rst_p5");
    for (int j = 1; j <= 8; j++) begin
      tick();
      check_all($sformatf("p5_dwell%0d", j));
    end

    // 200 free-running clocks: model, safety, one-hot and period checks.
    prev1 = {m1_a, m2_a, mt_a, s_a};
    prev2 = {m1_b, m2_b, mt_b, s_b};
    last1 = -1;
    last2 = -1;
    for (int j = 0; j < 200; j++) begin
      tick();
      check_all("run");
      if ({m1_a, m2_a, mt_a, s_a} == pat(0) && prev1 != pat(0)) begin
        if (last1 >= 0) check_int("period1", k - last1, 21);
        last1 = k;
      end
      if ({m1_b, m2_b, mt_b, s_b} == pat(0) && prev2 != pat(0)) begin
        if (last2 >= 0) check_int("period2", k - last2, 15);
        last2 = k;
      end
      prev1 = {m1_a, m2_a, mt_a, s_a};
      prev2 = {m1_b, m2_b, mt_b, s_b};
    end
    check_int("period1_seen", int'(last1 >= 0), 1);

    // Randomised run with async reset pulses at random offsets.
    for (int j = 0; j < 300; j++) begin
      if ($urandom_range(0, 24) == 0) begin
        #($urandom_range(1, 4));
        rst = 1'b0;
        #1;
        check("rnd_rst_imm1", {m1_a, m2_a, mt_a, s_a}, pat(0));
        check("rnd_rst_imm2", {m1_b, m2_b, mt_b, s_b}, pat(0));
        #($urandom_range(1, 2));
        rst = 1'b1;
        k   = 0;
      end
      tick();
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Fixed-time controller for a T-junction with four signal heads: main road direction 1 (M1), main road direction 2 (M2), main-road turn lane (MT) and side road (S). A single free-running state machine steps through a six-phase cycle. Each phase lasts a parameterised number of clock ticks; the system clock is nominally 1 Hz, so one tick is one second. Each head is driven with a one-hot red/yellow/green code, and the outputs go straight to the lamp drivers.

Parameters:
T_MAIN, 7, ticks in phase P1 (M1+M2 green)
T_YEL, 2, ticks in every yellow phase (P2, P4, P6)
T_TURN, 5, ticks in phase P3 (M1+MT green)
T_SIDE, 3, ticks in phase P5 (S green)
CNT_W, 4, timer width; must hold the largest duration minus 1

Ports:
clk  in  1  system clock, rising-edge active (1 Hz nominal)
rst  in  1  asynchronous, active-low reset
light_M1  out  3  main road dir-1 head, {red,yellow,green}
light_M2  out  3  main road dir-2 head, {red,yellow,green}
light_MT  out  3  main turn-lane head, {red,yellow,green}
light_S  out  3  side road head, {red,yellow,green}

Behaviour:
- Lamp encoding, one-hot: RED=3'b100, YEL=3'b010, GRN=3'b001. No other codes are ever driven.
- State register: phase (P1..P6) plus timer cnt[CNT_W-1:0].
- Reset (rst=0): asynchronous; phase<=P1, cnt<=0 immediately, independent of clk. While rst is held low, outputs show the P1 pattern. Release is sampled at the next clk rising edge.
- Outputs are a pure combinational decode of phase only, with no registered delay.
- Phase output patterns (M1,M2,MT,S):
  - P1: GRN,GRN,RED,RED
  - P2: GRN,YEL,RED,RED
  - P3: GRN,RED,GRN,RED
  - P4: YEL,RED,YEL,RED
  - P5: RED,RED,RED,GRN
  - P6: RED,RED,RED,YEL
- Timing per phase of duration D:
  - cnt increments on every rising edge.
  - On the edge where cnt==D-1, phase advances and cnt<=0.
  - Each phase is therefore visible for exactly D rising edges.
- Sequence: P1->P2->P3->P4->P5->P6->P1, repeating forever. No inputs alter the order.
- Default cycle length: 7+2+5+2+3+2 = 21 ticks.
- Safety invariants, true in every phase:
  - S is never non-red while any of M1, M2 or MT is non-red.
  - M2 and MT are never both non-red.
- Illegal or unreachable phase encoding: next state P1 with cnt<=0, and outputs all RED for that cycle.
- Reset asserted mid-phase: immediate return to P1, cnt=0. A full T_MAIN dwell follows after release.
- Timer never exceeds D-1 in any phase, so no wrap-around ambiguity.

Test Plan:
- Reset: drive rst=0 mid-P4 with no clk edge -> outputs immediately M1=100-independent? No: outputs immediately P1 pattern M1=001, M2=001, MT=100, S=100.
- Release rst, count edges -> P1 held 7 edges, then P2 (M2=010) for 2, P3 (MT=001, M2=100) for 5, P4 (M1=010, MT=010) for 2, P5 (S=001, others 100) for 3, P6 (S=010) for 2, back to P1 at edge 21.
- Run 200 clocks -> period exactly 21 edges; every output sample is one-hot in {100,010,001}.
- Safety checker on all 200 cycles -> S!=100 implies M1=M2=MT=100; never M2!=100 with MT!=100 simultaneously.
- Async reset pulse mid-P5 -> P1 shown at once; after release, P1 lasts the full 7 edges.
- Parameter override T_MAIN=3, T_SIDE=1 -> P1 lasts 3 edges, P5 lasts 1 edge, cycle length 15.
